sampitr_quad: RTL and testbench
===============================

SAMPITR_QUAD -- requirements
Module: sampitr_quad

Interface
REQ-001 Parameters SHALL be: SIGFIG, default 24, fixed-point word width; RADIX, default 10, fractional bits; VERTS, default 3, vertices; AXIS, default 3, axes per vertex; COLORS, default 3, color channels.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 tri_R13S  input  SIGFIG x VERTS x AXIS  signed triangle from bounding-box stage.
REQ-005 color_R13U  input  SIGFIG x COLORS  triangle color.
REQ-006 box_R13S  input  SIGFIG x 2 x 2  signed box, [0]=lower-left, [1]=upper-right, [.][0]=x, [.][1]=y, sample-grid aligned by upstream.
REQ-007 validTri_R13H  input  1  triangle and box valid.
REQ-008 subSample_RnnnnU  input  4  one-hot MSAA select, [3]=1, [2]=4, [1]=16, [0]=64; static while any triangle is in flight.
REQ-009 halt_RnnnnL  output  1  low = upstream stalls; a triangle is accepted on an edge where validTri_R13H=1 and halt_RnnnnL=1.
REQ-010 tri_R14S, color_R14U  output  same shapes as R13 inputs  registered copy of the accepted triangle.
REQ-011 sample_R14S  output  SIGFIG x 2 x 4  [axis][lane] sample positions, 4 lanes per cycle.
REQ-012 validSamp_R14H  output  1 x 4  per-lane valid.

Function
REQ-013 Step SHALL be 1<<RADIX, 1<<(RADIX-1), 1<<(RADIX-2), 1<<(RADIX-3) for subSample bits 3, 2, 1, 0.
REQ-014 FSM SHALL have two states: WAIT, with no triangle held, and TEST, with a triangle being iterated.
REQ-015 halt_RnnnnL SHALL be 1 in WAIT, and 1 in TEST only while the group currently on the outputs is the last group; otherwise it SHALL be 0.
REQ-016 On acceptance, the same edge SHALL register tri and color, enter TEST, and drive the first group: lane i x = ll_x + i*step, y = ll_y.
REQ-017 Lane i SHALL be valid iff state is TEST and lane x <= ur_x and y <= ur_y, using signed compares.
REQ-018 Advance in TEST without acceptance: if lane0 x + 4*step <= ur_x, add 4*step to every lane x; otherwise reset lanes to ll_x + i*step and add step to y.
REQ-019 Last group: lane0 x + 4*step > ur_x and y + step > ur_y. The next edge SHALL enter WAIT with all validSamp_R14H=0, unless a new triangle is accepted on that edge; acceptance wins and gives back-to-back groups with no bubble.
REQ-020 Latency: first group visible one edge after acceptance; a box of W x H samples SHALL take exactly ceil(W/4)*H cycles in TEST.
REQ-021 Arithmetic SHALL be SIGFIG-bit signed with no saturation; the coordinate range is guaranteed by upstream.
REQ-022 tri_R14S and color_R14U SHALL hold their values in WAIT.

Reset
REQ-023 While rst=0: state WAIT; all sample, tri and color outputs 0; validSamp_R14H all 0; halt_RnnnnL=1.
REQ-024 Reset asserted mid-TEST SHALL discard the triangle immediately; after release, no further group of it SHALL appear.

Configuration
REQ-025 With EMPTY_BOX_SKIP_EN defined: an accepted triangle with ur_x < ll_x or ur_y < ll_y SHALL be dropped, the FSM stays in WAIT, and no valid lane is emitted.
REQ-026 Without EMPTY_BOX_SKIP_EN: such a triangle SHALL enter TEST for exactly one cycle with all lanes invalid, then return to WAIT.

Verification
REQ-027 MSAA=1, box (1024,2048)-(4096,2048) -> one group: x=1024,2048,3072,4096, y=2048, valid 1111; halt_RnnnnL stays 1.
REQ-028 MSAA=1, box (1024,0)-(6144,0) -> group 1 valid 1111; group 2 x=5120,6144,7168,8192 valid 0011; then WAIT.
REQ-029 MSAA=4 (step 512), box (0,0)-(512,512) -> two groups, y=0 then y=512, each valid 0011; 2 TEST cycles.
REQ-030 Two triangles presented back-to-back -> second triangle's first group on the edge after the first triangle's last group, with no all-invalid cycle between.
REQ-031 rst=0 during the second group of REQ-028 -> outputs 0 and halt_RnnnnL=1 immediately; no group after release.
REQ-032 Box (2048,0)-(1024,0): with EMPTY_BOX_SKIP_EN -> zero TEST cycles; without it -> one TEST cycle, valid 0000.

Source files
------------

// File: rtl/sampitr_quad_if.sv
// Bus bundle between the bounding-box stage, the quad sample iterator and the sample-test stage.
// The master side feeds triangles in; the slave side (the iterator) returns the halt and quad samples.
interface sampitr_quad_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                          validTri_R13H;
  logic        [3:0]                             subSample_RnnnnU;
  logic                                          halt_RnnnnL;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic signed [1:0][3:0][SIGFIG-1:0]            sample_R14S;
  logic        [3:0]                             validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sampitr_quad.sv
// Quad sample iterator: walks a triangle's box four samples per cycle; EMPTY_BOX_SKIP_EN drops empty boxes.
// Latency: first quad one edge after acceptance, then ceil(W/4)*H cycles per triangle.
// Backpressure: halt_RnnnnL low stalls upstream except while the last quad is on the outputs.
module sampitr_quad #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input logic           clk,
  input logic           rst,
  sampitr_quad_if.slave bus
);
  typedef enum logic {WAIT, TEST} state_t;
  typedef logic signed [SIGFIG-1:0] coord_t;

  localparam coord_t STEP_1  = coord_t'(1) << RADIX;
  localparam coord_t STEP_4  = coord_t'(1) << (RADIX - 1);
  localparam coord_t STEP_16 = coord_t'(1) << (RADIX - 2);
  localparam coord_t STEP_64 = coord_t'(1) << (RADIX - 3);

  state_t state, state_nxt;
  coord_t step, step4;
  coord_t ll_x, ur_x, ur_y, y;
  coord_t lane_x [4];
  coord_t lane_off [4];
  coord_t nx0, ny;
  coord_t in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  logic   empty, in_empty, last_grp, accept, take;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q;

  always_comb begin
    step = STEP_1;
    if (bus.subSample_RnnnnU[2]) step = STEP_4;
    if (bus.subSample_RnnnnU[1]) step = STEP_16;
    if (bus.subSample_RnnnnU[0]) step = STEP_64;
    step4 = step << 2;
    for (int i = 0; i < 4; i++) lane_off[i] = coord_t'(i) * step;
  end

  always_comb begin
    in_ll_x  = bus.box_R13S[0][0];
    in_ll_y  = bus.box_R13S[0][1];
    in_ur_x  = bus.box_R13S[1][0];
    in_ur_y  = bus.box_R13S[1][1];
    in_empty = (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);
  end

  // An empty box is held as a single all-invalid quad so it never walks past its bounds.
  assign nx0      = lane_x[0] + step4;
  assign ny       = y + step;
  assign last_grp = empty || ((nx0 > ur_x) && (ny > ur_y));

  assign bus.halt_RnnnnL = (state == WAIT) || last_grp;
  assign accept          = bus.validTri_R13H && bus.halt_RnnnnL;

`ifdef EMPTY_BOX_SKIP_EN
  assign take = accept && !in_empty;
`else
  assign take = accept;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (take)                              state_nxt = TEST;
    else if (state == TEST && last_grp)    state_nxt = WAIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_q   <= '0;
      color_q <= '0;
      ll_x    <= '0;
      ur_x    <= '0;
      ur_y    <= '0;
      y       <= '0;
      empty   <= 1'b0;
      for (int i = 0; i < 4; i++) lane_x[i] <= '0;
    end else if (take) begin
      tri_q   <= bus.tri_R13S;
      color_q <= bus.color_R13U;
      ll_x    <= in_ll_x;
      ur_x    <= in_ur_x;
      ur_y    <= in_ur_y;
      y       <= in_ll_y;
      empty   <= in_empty;
      for (int i = 0; i < 4; i++) lane_x[i] <= in_ll_x + lane_off[i];
    end else if (state == TEST && !last_grp) begin
      if (nx0 <= ur_x) begin
        for (int i = 0; i < 4; i++) lane_x[i] <= lane_x[i] + step4;
      end else begin
        for (int i = 0; i < 4; i++) lane_x[i] <= ll_x + lane_off[i];
        y <= ny;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.sample_R14S[0][i]  = lane_x[i];
      bus.sample_R14S[1][i]  = y;
      bus.validSamp_R14H[i]  = (state == TEST) && (lane_x[i] <= ur_x) && (y <= ur_y);
    end
  end

  assign bus.tri_R14S   = tri_q;
  assign bus.color_R14U = color_q;
endmodule

// File: tb/tb_sampitr_quad.sv
// Bench for sampitr_quad: directed spec scenarios plus a randomized triangle stream
// scored against a box-walking reference model.
module tb_sampitr_quad;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int TRIW   = VERTS * AXIS * SIGFIG;
  localparam int COLW   = COLORS * SIGFIG;

  typedef logic signed [SIGFIG-1:0] crd_t;
  typedef struct {
    int llx, lly, urx, ury;
    logic [TRIW-1:0] tri_bits;
    logic [COLW-1:0] col_bits;
    int idle;
  } tri_t;
  typedef struct {
    int x0, y;
    logic [3:0] mask;
    bit last;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sampitr_quad_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

  sampitr_quad #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int step;
  tri_t pend[$];
  grp_t cur[$];
  bit in_test = 0;
  logic [TRIW-1:0] exp_tri = '0;
  logic [COLW-1:0] exp_col = '0;

  function automatic bit is_empty(input tri_t t);
    return (t.urx < t.llx) || (t.ury < t.lly);
  endfunction

  // Expected quads: W x H sample grid cut into rows of 4-wide groups.
  function automatic void build(input tri_t t);
    int w, h, ng;
    grp_t g;
    if (is_empty(t)) begin
      g.x0 = t.llx; g.y = t.lly; g.mask = 4'b0000; g.last = 1;
      cur.push_back(g);
      return;
    end
    w  = (t.urx - t.llx) / step + 1;
    h  = (t.ury - t.lly) / step + 1;
    ng = (w + 3) / 4;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < ng; c++) begin
        g.x0 = t.llx + 4 * c * step;
        g.y  = t.lly + r * step;
        for (int i = 0; i < 4; i++) g.mask[i] = (4 * c + i < w);
        g.last = (r == h - 1) && (c == ng - 1);
        cur.push_back(g);
      end
  endfunction

  function automatic tri_t rand_tri(input int llx, lly, urx, ury, idle);
    tri_t t;
    t.llx = llx; t.lly = lly; t.urx = urx; t.ury = ury; t.idle = idle;
    for (int k = 0; k < TRIW; k++) t.tri_bits[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < COLW; k++) t.col_bits[k] = 1'($urandom_range(0, 1));
    return t;
  endfunction

  function automatic bit skip_empty();
`ifdef EMPTY_BOX_SKIP_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  // Drives the pend queue into the DUT and scores every cycle until idle.
  task automatic run_stream(input int sub_bit, output int tcyc);
    int idle_cnt = 0;
    int cyc = 0;
    bit acc, exp_halt;
    tri_t t;
    grp_t g;
    tcyc = 0;
    step = 1 << (RADIX - 3 + sub_bit);
    bus.subSample_RnnnnU = 4'(1 << sub_bit);
    while ((pend.size() != 0 || in_test) && cyc < 5000) begin
      cyc++;
      if (in_test) begin
        g = cur[0];
        checks++;
        if (bus.validSamp_R14H !== g.mask) begin
          errors++; $display("FAIL valid: got %b want %b", bus.validSamp_R14H, g.mask);
        end
        checks++;
        if (bus.sample_R14S[1][0] !== crd_t'(g.y)) begin
          errors++; $display("FAIL lane_y: got %0d want %0d", $signed(bus.sample_R14S[1][0]), g.y);
        end
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (bus.sample_R14S[0][i] !== crd_t'(g.x0 + i * step)) begin
            errors++;
            $display("FAIL lane_x[%0d]: got %0d want %0d", i, $signed(bus.sample_R14S[0][i]), g.x0 + i * step);
          end
        end
        checks++;
        if (bus.halt_RnnnnL !== g.last) begin
          errors++; $display("FAIL halt_test: got %b want %b", bus.halt_RnnnnL, g.last);
        end
      end else begin
        checks++;
        if (bus.validSamp_R14H !== 4'b0000 || bus.halt_RnnnnL !== 1'b1) begin
          errors++; $display("FAIL wait_state: valid %b halt %b want 0000/1", bus.validSamp_R14H, bus.halt_RnnnnL);
        end
      end
      checks++;
      if (bus.tri_R14S !== exp_tri || bus.color_R14U !== exp_col) begin
        errors++; $display("FAIL tri_color: registered copy differs from last accepted triangle");
      end
      acc = 0;
      bus.validTri_R13H = 1'b0;
      if (pend.size() != 0) begin
        if (idle_cnt < pend[0].idle) idle_cnt++;
        else begin
          t = pend[0];
          bus.validTri_R13H = 1'b1;
          bus.tri_R13S      = t.tri_bits;
          bus.color_R13U    = t.col_bits;
          bus.box_R13S[0][0] = crd_t'(t.llx);
          bus.box_R13S[0][1] = crd_t'(t.lly);
          bus.box_R13S[1][0] = crd_t'(t.urx);
          bus.box_R13S[1][1] = crd_t'(t.ury);
          exp_halt = in_test ? cur[0].last : 1'b1;
          acc = exp_halt;
        end
      end
      @(posedge clk);
      if (in_test) begin
        tcyc++;
        void'(cur.pop_front());
        if (cur.size() == 0) in_test = 0;
      end
      if (acc) begin
        t = pend.pop_front();
        idle_cnt = 0;
        if (!(skip_empty() && is_empty(t))) begin
          exp_tri = t.tri_bits;
          exp_col = t.col_bits;
          build(t);
          in_test = 1;
        end
      end
      @(negedge clk);
    end
    bus.validTri_R13H = 1'b0;
    checks++;
    if (cyc >= 5000) begin
      errors++; $display("FAIL stream_timeout: %0d cycles, want fewer than 5000", cyc);
    end
    checks++;
    if (bus.validSamp_R14H !== 4'b0000 || bus.halt_RnnnnL !== 1'b1) begin
      errors++; $display("FAIL end_wait: valid %b halt %b want 0000/1", bus.validSamp_R14H, bus.halt_RnnnnL);
    end
  endtask

  task automatic test_reset();
    bus.validTri_R13H = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    bus.tri_R13S = '0; bus.color_R13U = '0; bus.box_R13S = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.validSamp_R14H !== 4'b0000 || bus.halt_RnnnnL !== 1'b1 || bus.sample_R14S !== '0 ||
        bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin
      errors++; $display("FAIL reset_state: valid %b halt %b, want zeros and halt 1", bus.validSamp_R14H, bus.halt_RnnnnL);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_group();
    int tc;
    pend.push_back(rand_tri(1024, 2048, 4096, 2048, 0));
    run_stream(3, tc);
    checks++;
    if (tc !== 1) begin errors++; $display("FAIL single_group_cycles: got %0d want 1", tc); end
  endtask

  task automatic test_two_groups();
    int tc;
    pend.push_back(rand_tri(1024, 0, 6144, 0, 1));
    run_stream(3, tc);
    checks++;
    if (tc !== 2) begin errors++; $display("FAIL two_group_cycles: got %0d want 2", tc); end
  endtask

  task automatic test_msaa4();
    int tc;
    pend.push_back(rand_tri(0, 0, 512, 512, 0));
    run_stream(2, tc);
    checks++;
    if (tc !== 2) begin errors++; $display("FAIL msaa4_cycles: got %0d want 2", tc); end
  endtask

  task automatic test_back_to_back();
    int tc;
    pend.push_back(rand_tri(1024, 0, 6144, 1024, 0));
    pend.push_back(rand_tri(-2048, 3072, 0, 3072, 0));
    run_stream(3, tc);
    checks++;
    if (tc !== 5) begin errors++; $display("FAIL b2b_cycles: got %0d want 5", tc); end
  endtask

  task automatic test_empty_box();
    int tc;
    pend.push_back(rand_tri(2048, 0, 1024, 0, 0));
    run_stream(3, tc);
    checks++;
    if (tc !== (skip_empty() ? 0 : 1)) begin
      errors++; $display("FAIL empty_box_cycles: got %0d want %0d", tc, skip_empty() ? 0 : 1);
    end
  endtask

  task automatic test_reset_mid();
    tri_t t;
    t = rand_tri(1024, 0, 6144, 0, 0);
    bus.subSample_RnnnnU = 4'b1000;
    bus.tri_R13S = t.tri_bits; bus.color_R13U = t.col_bits;
    bus.box_R13S[0][0] = 24'sd1024; bus.box_R13S[0][1] = '0;
    bus.box_R13S[1][0] = 24'sd6144; bus.box_R13S[1][1] = '0;
    bus.validTri_R13H = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.validSamp_R14H !== 4'b1111 || bus.halt_RnnnnL !== 1'b0) begin
      errors++; $display("FAIL rst_mid_g1: valid %b halt %b want 1111/0", bus.validSamp_R14H, bus.halt_RnnnnL);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.validSamp_R14H !== 4'b0011 || bus.sample_R14S[0][0] !== 24'sd5120) begin
      errors++; $display("FAIL rst_mid_g2: valid %b x0 %0d want 0011/5120", bus.validSamp_R14H, $signed(bus.sample_R14S[0][0]));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.validSamp_R14H !== 4'b0000 || bus.halt_RnnnnL !== 1'b1 || bus.sample_R14S !== '0 ||
        bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin
      errors++; $display("FAIL rst_mid_clear: valid %b halt %b want zeros and halt 1", bus.validSamp_R14H, bus.halt_RnnnnL);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_tri = '0; exp_col = '0; in_test = 0; cur.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.validSamp_R14H !== 4'b0000 || bus.halt_RnnnnL !== 1'b1) begin
        errors++; $display("FAIL rst_mid_after: valid %b halt %b want 0000/1", bus.validSamp_R14H, bus.halt_RnnnnL);
      end
    end
  endtask

  task automatic test_random();
    int tc, want, sb, stp, w, h, llx, lly;
    for (int rnd = 0; rnd < 4; rnd++) begin
      sb   = $urandom_range(0, 3);
      stp  = 1 << (RADIX - 3 + sb);
      want = 0;
      for (int n = 0; n < 8; n++) begin
        w   = $urandom_range(1, 11);
        h   = $urandom_range(1, 4);
        llx = stp * ($urandom_range(0, 40) - 20);
        lly = stp * ($urandom_range(0, 40) - 20);
        pend.push_back(rand_tri(llx, lly, llx + (w - 1) * stp, lly + (h - 1) * stp, $urandom_range(0, 2)));
        want += ((w + 3) / 4) * h;
      end
      run_stream(sb, tc);
      checks++;
      if (tc !== want) begin errors++; $display("FAIL random_cycles: got %0d want %0d", tc, want); end
    end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_two_groups();
    test_msaa4();
    test_back_to_back();
    test_empty_box();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
